// File: rtl/usb_kbd_report_tx.sv
// usb_kbd_report_tx: HID boot-keyboard report transmitter.
// The CPU pushes ASCII characters over a small register bus. Each character
// is queued, translated to {modifier, scancode} and sent as an 8-byte press
// report followed by an 8-byte all-zero release report on a valid/ready stream.
// A fixed idle gap follows each report to emulate the host poll interval.
// Optional feature macro: KBD_TX_IRQ_EN (adds irq_o, "queue drained" interrupt).
module usb_kbd_report_tx #(
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_CYCLES = 1000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       R_W_n,
    input  logic [7:0] reg_addr_i,
    input  logic [7:0] data_i,
    input  logic       kbd_cs,
    output logic [7:0] data_o,
    output logic [7:0] rpt_data_o,
    output logic       rpt_valid_o,
    output logic       rpt_last_o,
    input  logic       rpt_ready_i
`ifdef KBD_TX_IRQ_EN
    ,
    output logic       irq_o
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam logic [31:0] GAP_LAST = 32'(GAP_EFF - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_PRESS   = 3'd2;
    localparam logic [2:0] S_GAP1    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_GAP2    = 3'd5;

    // Returns {mappable, modifier, scancode} for one ASCII code (US layout).
    function automatic logic [16:0] kbd_xlat(input logic [7:0] c);
        logic [16:0] r;
        r = 17'h0_0000;
        if (c >= 8'h61 && c <= 8'h7A) begin
            r = {1'b1, 8'h00, c - 8'h5D};
        end else if (c >= 8'h41 && c <= 8'h5A) begin
            r = {1'b1, 8'h02, c - 8'h3D};
        end else if (c >= 8'h31 && c <= 8'h39) begin
            r = {1'b1, 8'h00, c - 8'h13};
        end else if (c >= 8'h01 && c <= 8'h1A && c != 8'h08 && c != 8'h09 && c != 8'h0D) begin
            r = {1'b1, 8'h01, c + 8'h03};
        end else begin
            case (c)
                8'h30: r = {1'b1, 8'h00, 8'h27};
                8'h0D: r = {1'b1, 8'h00, 8'h28};
                8'h1B: r = {1'b1, 8'h00, 8'h29};
                8'h08: r = {1'b1, 8'h00, 8'h2A};
                8'h09: r = {1'b1, 8'h00, 8'h2B};
                8'h20: r = {1'b1, 8'h00, 8'h2C};
                8'h2D: r = {1'b1, 8'h00, 8'h2D};
                8'h3D: r = {1'b1, 8'h00, 8'h2E};
                8'h5B: r = {1'b1, 8'h00, 8'h2F};
                8'h5D: r = {1'b1, 8'h00, 8'h30};
                8'h5C: r = {1'b1, 8'h00, 8'h31};
                8'h3B: r = {1'b1, 8'h00, 8'h33};
                8'h27: r = {1'b1, 8'h00, 8'h34};
                8'h60: r = {1'b1, 8'h00, 8'h35};
                8'h2C: r = {1'b1, 8'h00, 8'h36};
                8'h2E: r = {1'b1, 8'h00, 8'h37};
                8'h2F: r = {1'b1, 8'h00, 8'h38};
                8'h5F: r = {1'b1, 8'h02, 8'h2D};
                8'h2B: r = {1'b1, 8'h02, 8'h2E};
                8'h7B: r = {1'b1, 8'h02, 8'h2F};
                8'h7D: r = {1'b1, 8'h02, 8'h30};
                8'h7C: r = {1'b1, 8'h02, 8'h31};
                8'h3A: r = {1'b1, 8'h02, 8'h33};
                8'h22: r = {1'b1, 8'h02, 8'h34};
                8'h7E: r = {1'b1, 8'h02, 8'h35};
                8'h3C: r = {1'b1, 8'h02, 8'h36};
                8'h3E: r = {1'b1, 8'h02, 8'h37};
                8'h3F: r = {1'b1, 8'h02, 8'h38};
                8'h21: r = {1'b1, 8'h02, 8'h1E};
                8'h40: r = {1'b1, 8'h02, 8'h1F};
                8'h23: r = {1'b1, 8'h02, 8'h20};
                8'h24: r = {1'b1, 8'h02, 8'h21};
                8'h25: r = {1'b1, 8'h02, 8'h22};
                8'h5E: r = {1'b1, 8'h02, 8'h23};
                8'h26: r = {1'b1, 8'h02, 8'h24};
                8'h2A: r = {1'b1, 8'h02, 8'h25};
                8'h28: r = {1'b1, 8'h02, 8'h26};
                8'h29: r = {1'b1, 8'h02, 8'h27};
                default: r = 17'h0_0000;
            endcase
        end
        return r;
    endfunction

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          enable_q, overflow_q, badchar_q;
    logic [2:0]    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d, key_q, key_d;
    logic          valid_q, valid_d, last_q, last_d;
    logic [31:0]   gap_q, gap_d;
    logic          badchar_set_s;

    logic wr_s, push_req_s, push_s, pop_s, full_s, empty_s, ctrl_wr_s, busy_s, hs_s;
    logic [16:0] xlat_s;

    assign wr_s       = kbd_cs & ~R_W_n;
    assign push_req_s = wr_s & (reg_addr_i == 8'h00);
    assign ctrl_wr_s  = wr_s & (reg_addr_i == 8'h02);
    assign full_s     = (count_q == CW'(FIFO_DEPTH));
    assign empty_s    = (count_q == CW'(0));
    assign pop_s      = (state_q == S_LOAD);
    // A simultaneous pop frees a slot, so a write to a full FIFO is still taken.
    assign push_s     = push_req_s & (~full_s | pop_s);
    assign busy_s     = (state_q != S_IDLE);
    assign hs_s       = valid_q & rpt_ready_i;
    assign xlat_s     = kbd_xlat(mem_q[rd_ptr_q]);

    assign rpt_data_o  = data_q;
    assign rpt_valid_o = valid_q;
    assign rpt_last_o  = last_q;

    // Character storage; contents need no reset since the pointers qualify them.
    always_ff @(posedge clk_i) begin
        if (push_s) mem_q[wr_ptr_q] <= data_i;
    end

    // FIFO pointers and fill level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_s && !pop_s)      count_q <= count_q + CW'(1);
            else if (pop_s && !push_s) count_q <= count_q - CW'(1);
        end
    end

    // Control and sticky status bits; a set in the same cycle as a clear wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enable_q   <= 1'b0;
            overflow_q <= 1'b0;
            badchar_q  <= 1'b0;
        end else begin
            if (ctrl_wr_s) enable_q <= data_i[0];
            if (push_req_s && full_s && !pop_s)  overflow_q <= 1'b1;
            else if (ctrl_wr_s && data_i[1])     overflow_q <= 1'b0;
            if (badchar_set_s)                   badchar_q <= 1'b1;
            else if (ctrl_wr_s && data_i[2])     badchar_q <= 1'b0;
        end
    end

    // Report sequencer next-state; outputs are precomputed so they leave registered.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        data_d        = data_q;
        valid_d       = valid_q;
        last_d        = last_q;
        gap_d         = gap_q;
        key_d         = key_q;
        badchar_set_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_q && !empty_s) state_d = S_LOAD;
                else                      state_d = S_IDLE;
            end
            S_LOAD: begin
                if (xlat_s[16]) begin
                    state_d = S_PRESS;
                    key_d   = xlat_s[7:0];
                    data_d  = xlat_s[15:8];
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    idx_d   = 3'd0;
                end else begin
                    state_d       = S_IDLE;
                    badchar_set_s = 1'b1;
                end
            end
            S_PRESS, S_RELEASE: begin
                if (hs_s) begin
                    if (idx_q == 3'd7) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = 8'h00;
                        gap_d   = GAP_LAST;
                        state_d = (state_q == S_PRESS) ? S_GAP1 : S_GAP2;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        last_d = (idx_q == 3'd6);
                        data_d = (state_q == S_PRESS && idx_q == 3'd1) ? key_q : 8'h00;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_GAP1: begin
                if (gap_q == 32'd0) begin
                    state_d = S_RELEASE;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    data_d  = 8'h00;
                    idx_d   = 3'd0;
                end else begin
                    gap_d = gap_q - 32'd1;
                end
            end
            S_GAP2: begin
                if (gap_q == 32'd0) state_d = S_IDLE;
                else                gap_d   = gap_q - 32'd1;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                data_d  = 8'h00;
            end
        endcase
    end

    // Report sequencer state and registered stream outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            gap_q   <= 32'd0;
            key_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            key_q   <= key_d;
        end
    end

    // Register read mux.
    always_comb begin
        data_o = 8'h00;
        case (reg_addr_i)
            8'h00:   data_o = {4'b0000, badchar_q, overflow_q, full_s, empty_s};
            8'h01:   data_o = 8'(count_q);
            8'h02:   data_o = {7'b000_0000, enable_q};
            8'h03:   data_o = {7'b000_0000, busy_s};
            default: data_o = 8'h00;
        endcase
    end

`ifdef KBD_TX_IRQ_EN
    logic irq_armed_q;
    logic rd_status_s;

    assign rd_status_s = kbd_cs & R_W_n & (reg_addr_i == 8'h00);

    // Arm on any accepted push, disarm when software reads the status register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)            irq_armed_q <= 1'b0;
        else if (push_s)      irq_armed_q <= 1'b1;
        else if (rd_status_s) irq_armed_q <= 1'b0;
    end

    assign irq_o = enable_q & empty_s & ~busy_s & irq_armed_q;
`endif

endmodule

// File: tb/tb_usb_kbd_report_tx.sv
// Self-checking bench for usb_kbd_report_tx (GAP_CYCLES = 4, FIFO_DEPTH = 16).
// Expected report bytes are queued when a character is pushed and compared
// as the DUT hands them over.
module tb_usb_kbd_report_tx;
    localparam int GAP   = 4;
    localparam int DEPTH = 16;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       R_W_n = 1'b1;
    logic       kbd_cs = 1'b0;
    logic       rpt_ready_i = 1'b1;
    logic [7:0] reg_addr_i = 8'h00;
    logic [7:0] data_i = 8'h00;
    logic [7:0] data_o, rpt_data_o;
    logic       rpt_valid_o, rpt_last_o;
`ifdef KBD_TX_IRQ_EN
    logic       irq_o;
`endif

    usb_kbd_report_tx #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .R_W_n(R_W_n), .reg_addr_i(reg_addr_i),
        .data_i(data_i), .kbd_cs(kbd_cs), .data_o(data_o),
        .rpt_data_o(rpt_data_o), .rpt_valid_o(rpt_valid_o),
        .rpt_last_o(rpt_last_o), .rpt_ready_i(rpt_ready_i)
`ifdef KBD_TX_IRQ_EN
        , .irq_o(irq_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_bad   = 0;
    logic [8:0] sb_q [$];

    int         rx_cnt = 0;
    bit         is_rel = 1'b0;
    bit         gap_armed = 1'b0;
    int         gap_cnt = 0;
    bit         prev_v = 1'b0;
    bit         prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference translation, written from the key tables rather than a case list.
    function automatic void tb_xlat(input logic [7:0] c, output logic ok,
                                    output logic [7:0] m, output logic [7:0] k);
        logic [7:0] uns  [11];
        logic [7:0] shf  [11];
        logic [7:0] sdig [10];
        uns  = '{8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h60, 8'h2C, 8'h2E, 8'h2F};
        shf  = '{8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h7E, 8'h3C, 8'h3E, 8'h3F};
        sdig = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28, 8'h29};
        ok = 1'b1; m = 8'h00; k = 8'h00;
        if (c >= 8'h61 && c <= 8'h7A)      k = 8'h04 + (c - 8'h61);
        else if (c >= 8'h41 && c <= 8'h5A) begin m = 8'h02; k = 8'h04 + (c - 8'h41); end
        else if (c == 8'h30)               k = 8'h27;
        else if (c >= 8'h31 && c <= 8'h39) k = 8'h1E + (c - 8'h31);
        else if (c == 8'h0D)               k = 8'h28;
        else if (c == 8'h1B)               k = 8'h29;
        else if (c == 8'h08)               k = 8'h2A;
        else if (c == 8'h09)               k = 8'h2B;
        else if (c == 8'h20)               k = 8'h2C;
        else if (c >= 8'h01 && c <= 8'h1A) begin m = 8'h01; k = 8'h04 + (c - 8'h01); end
        else begin
            ok = 1'b0;
            for (int i = 0; i < 11; i++) begin
                if (c == uns[i]) begin ok = 1'b1; m = 8'h00; k = (i < 5) ? 8'h2D + 8'(i) : 8'h2E + 8'(i); end
                if (c == shf[i]) begin ok = 1'b1; m = 8'h02; k = (i < 5) ? 8'h2D + 8'(i) : 8'h2E + 8'(i); end
            end
            for (int i = 0; i < 10; i++) begin
                if (c == sdig[i]) begin ok = 1'b1; m = 8'h02; k = 8'h1E + 8'(i); end
            end
        end
    endfunction

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        kbd_cs = 1'b1; R_W_n = 1'b0; reg_addr_i = a; data_i = d;
        @(posedge clk_i); #1;
        kbd_cs = 1'b0; R_W_n = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        kbd_cs = 1'b1; R_W_n = 1'b1; reg_addr_i = a;
        #2 d = data_o;
        chk(tag, d, exp);
        @(posedge clk_i); #1;
        kbd_cs = 1'b0;
    endtask

    task automatic push_char(input logic [7:0] c);
        logic ok;
        logic [7:0] m, k;
        tb_xlat(c, ok, m, k);
        if (ok) begin
            for (int i = 0; i < 8; i++)
                sb_q.push_back({(i == 7), (i == 0) ? m : ((i == 2) ? k : 8'h00)});
            for (int i = 0; i < 8; i++)
                sb_q.push_back({(i == 7), 8'h00});
        end
        bus_wr(8'h00, c);
    endtask

    task automatic wait_drain(input string tag);
        int g = 0;
        while (sb_q.size() != 0 && g < 4000) begin @(posedge clk_i); #1; g++; end
        chk({tag, "_drain"}, sb_q.size(), 0);
        repeat (GAP + 4) @(posedge clk_i);
        #1;
        rd_chk({tag, "_busy"}, 8'h03, 8'h00);
    endtask

    // Stream monitor: scoreboard compare, stall stability and gap length.
    always @(negedge clk_i) begin
        if (rst_i) begin
            rx_cnt = 0; is_rel = 1'b0; gap_armed = 1'b0; gap_cnt = 0;
            prev_v = 1'b0; prev_r = 1'b0; prev_d = 8'h00;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", rpt_valid_o, 1);
                chk("hold_data", rpt_data_o, prev_d);
            end
            if (gap_armed) begin
                if (rpt_valid_o) begin chk("gap_len", gap_cnt, GAP); gap_armed = 1'b0; end
                else gap_cnt++;
            end
            if (rpt_valid_o && rpt_ready_i) begin
                logic [8:0] exp;
                exp = (sb_q.size() != 0) ? sb_q.pop_front() : 9'h1FF;
                chk("rpt_byte", {rpt_last_o, rpt_data_o}, exp);
                rx_cnt++;
                if (rpt_last_o) begin
                    rx_cnt = 0;
                    if (!is_rel) begin gap_armed = 1'b1; gap_cnt = 0; end
                    is_rel = !is_rel;
                end
            end
            prev_v = rpt_valid_o; prev_r = rpt_ready_i; prev_d = rpt_data_o;
        end
    end

    initial begin
        logic [7:0] tbl [6];
        string hello;
        int g;
        tbl = '{8'h0D, 8'h1B, 8'h03, 8'h7E, 8'h30, 8'h3F};
        hello = "hello world 123!";

        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("rst_valid0", rpt_valid_o, 0);
        chk("rst_last0", rpt_last_o, 0);
        chk("rst_data0", rpt_data_o, 0);
        rd_chk("rst_status", 8'h00, 8'h01);
        rd_chk("rst_level", 8'h01, 8'h00);
        rd_chk("rst_ctrl", 8'h02, 8'h00);
        rd_chk("rst_busy", 8'h03, 8'h00);

        // Basic 'a' report with latency check.
        bus_wr(8'h02, 8'h01);
        rd_chk("en_read", 8'h02, 8'h01);
        push_char(8'h61);
        g = 0;
        while (!rpt_valid_o && g < 20) begin @(posedge clk_i); #1; g++; end
        chk("latency", g, 2);
        wait_drain("a");

        // Shifted letter and shifted digit back to back.
        push_char(8'h41);
        push_char(8'h21);
        wait_drain("A_bang");

        // Backpressure for 10 cycles at byte 2.
        push_char(8'h61);
        g = 0;
        while (rx_cnt != 2 && g < 100) begin @(posedge clk_i); #1; g++; end
        chk("stall_reach", rx_cnt, 2);
        rpt_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            chk("stall_data", rpt_data_o, 8'h04);
            chk("stall_valid", rpt_valid_o, 1);
        end
        rpt_ready_i = 1'b1;
        wait_drain("stall");

        // Overflow: 17 pushes while disabled.
        bus_wr(8'h02, 8'h00);
        for (int i = 0; i < 16; i++) push_char(hello[i]);
        bus_wr(8'h00, 8'h78);
        rd_chk("ovf_level", 8'h01, 8'h10);
        rd_chk("ovf_status", 8'h00, 8'h06);
        bus_wr(8'h02, 8'h02);
        rd_chk("ovf_clr", 8'h00, 8'h02);
        bus_wr(8'h02, 8'h01);
        wait_drain("hello");

        // Unmappable code then a normal one, plus assorted mappings.
        push_char(8'h80);
        push_char(8'h62);
        for (int i = 0; i < 6; i++) push_char(tbl[i]);
        wait_drain("bad");
        rd_chk("bad_status", 8'h00, 8'h09);
        bus_wr(8'h02, 8'h05);
        rd_chk("bad_clr", 8'h00, 8'h01);

        // Reset in the middle of a press report.
        rpt_ready_i = 1'b0;
        push_char(8'h63);
        g = 0;
        while (!rpt_valid_o && g < 50) begin @(posedge clk_i); #1; g++; end
        chk("rst_wait", rpt_valid_o, 1);
        rpt_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        chk("midrst_valid", rpt_valid_o, 0);
        chk("midrst_last", rpt_last_o, 0);
        sb_q.delete();
        rd_chk("midrst_status", 8'h00, 8'h01);
        rd_chk("midrst_level", 8'h01, 8'h00);
        rst_i = 1'b0;
        rd_chk("midrst_en", 8'h02, 8'h00);
        bus_wr(8'h02, 8'h01);
        push_char(8'h64);
        wait_drain("after_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
